instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//   Fetch stage in front of the instruction ROM. Holds the program counter and drives the ROM word
//   address. Pairs each ROM output word with its PC and hands it to decode with a valid flag.
//   Handles the ROM's one-cycle registered read latency, pipeline stalls and branch/jump redirects.
// PARAMETERS
//   ADDR_WIDTH  14          ROM word-address width; ROM covers byte PCs 0 .. 2^(ADDR_WIDTH+2)-1
//   RESET_PC    32'h0       byte PC fetched first after reset; must be 4-byte aligned
// PORTS
//   clk            in   1           clock; all state updates on posedge
//   rst_n          in   1           asynchronous, active-low reset
//   stall_i        in   1           decode cannot accept; hold current instruction
//   redirect_i     in   1           taken branch/jump from execute; overrides stall_i
//   redirect_pc_i  in   32          redirect target byte PC
//   rom_addr_o     out  ADDR_WIDTH  ROM word address (combinational)
//   rom_data_i     in   32          ROM read data; registered, one cycle after rom_addr_o
//   instr_o        out  32          instruction to decode; NOP (32'h00000013) when valid_o=0
//   pc_o           out  32          byte PC of instr_o
//   pc_plus4_o     out  32          pc_o + 4 (link value for JAL/JALR)
//   valid_o        out  1           instr_o/pc_o are a real, in-path instruction
//   fault_o        out  1           misaligned redirect seen; sticky until reset
// BEHAVIOUR
//   State: pc_q (32b), state in {BOOT, RUN, FAULT}. Invariant: in RUN, rom_data_i is the word at pc_q.
//   Reset (rst_n=0, async): state=BOOT, pc_q=RESET_PC. Outputs: valid_o=0, fault_o=0, instr_o=NOP,
//     pc_o=RESET_PC, rom_addr_o=RESET_PC[ADDR_WIDTH+1:2].
//   next_pc:
//     BOOT           -> RESET_PC. stall_i and redirect_i are ignored.
//     RUN, redirect  -> redirect_pc_i.
//     RUN, stall     -> pc_q. The ROM re-reads the same word, so the output is held stable.
//     RUN, otherwise -> pc_q + 4. 32-bit add, wraps at 2^32.
//     FAULT          -> pc_q (frozen).
//   rom_addr_o = next_pc[ADDR_WIDTH+1:2]. Upper PC bits are ignored, so the ROM aliases (wraps).
//     pc_o keeps the full 32 bits.
//   Transitions on posedge:
//     BOOT -> RUN unconditionally. Exactly one bubble after reset release.
//     RUN -> FAULT when redirect_i=1 and redirect_pc_i[1:0]!=0; pc_q is not updated.
//     FAULT is held until rst_n=0.
//   Each edge: pc_q <= next_pc, except on the FAULT entry edge.
//   valid_o = (state==RUN) && !redirect_i.
//     Redirect cycle: the presented word is wrong-path and is killed combinationally.
//     The target instruction appears with valid_o=1 on the very next cycle: 1-cycle redirect penalty.
//   Stall with valid_o=1: instr_o, pc_o and valid_o stay constant every stalled cycle.
//   redirect_i && stall_i: redirect wins. Decode sees valid_o=0, so nothing needs to be accepted.
//   Redirect to the current pc_q (self-loop) behaves as a normal redirect.
//   Reset asserted mid-run: immediate async return to BOOT. The next instruction delivered is RESET_PC.
//   fault_o = (state==FAULT). It rises the cycle after the bad redirect. In FAULT: valid_o=0, instr_o=NOP.
//   pc_plus4_o = pc_o + 4, combinational.
// STRUCTURE
//   Shared package/include (riscv_defs): XLEN=32, ILEN=32, INSTR_NOP=32'h00000013,
//     fetch-state encodings (BOOT/RUN/FAULT, 2-bit).
//   Single module with no sub-modules. The next-PC mux is inline; the adder is shared with pc_plus4_o.
//   Top level: rom_addr_o -> ROM addr, ROM dataOut -> rom_data_i. Both blocks on the same clk.
// TESTING
//   Bench uses a behavioural 1-cycle registered ROM model with word[i] = 32'hA000_0000 + i.
//   1. Reset release, RESET_PC=0, no stall.
//      -> cycle 0: valid_o=0. Cycles 1..4: pc_o = 0,4,8,12; instr_o = A0000000..A0000003.
//   2. stall_i high 3 cycles while pc_o=8.
//      -> pc_o=8, instr_o=A0000002, valid_o=1 for all 3 cycles; then pc_o=12.
//   3. redirect_i with redirect_pc_i=0x40 while pc_o=8.
//      -> valid_o=0 that cycle; next cycle pc_o=0x40, instr_o=A0000010, valid_o=1.
//   4. redirect_i and stall_i together, target 0x20.
//      -> valid_o=0, then pc_o=0x20 valid; the stall has no effect.
//   5. Redirect to 0x22.
//      -> next cycle fault_o=1, valid_o=0, instr_o=NOP, pc_o unchanged. Stays so until rst_n pulse,
//         after which the scenario 1 sequence repeats.
//   6. Redirect to 0x0000_FFFC (ADDR_WIDTH=14), then run on.
//      -> rom_addr_o goes 16383 then 0; pc_o=0x0001_0000 with instr_o=A0000000 (alias wrap).
//   7. rst_n pulsed low mid-stream, asynchronously between edges.
//      -> outputs return to reset values immediately; sequence restarts per scenario 1.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared RISC-V fetch definitions: data widths, the canonical NOP and fetch-state encodings.
package instr_fetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses a 1-cycle registered ROM and pairs each word with its PC.
// One bubble after reset, 1-cycle redirect penalty; stall re-reads the same word to hold outputs.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              ADDR_WIDTH = 14,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [XLEN-1:0]       redirect_pc_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [ILEN-1:0]       rom_data_i,
  output logic [ILEN-1:0]       instr_o,
  output logic [XLEN-1:0]       pc_o,
  output logic [XLEN-1:0]       pc_plus4_o,
  output logic                  valid_o,
  output logic                  fault_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, next_pc, pc_inc;
  logic            fault_entry;

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    next_pc     = pc_q;
    fault_entry = 1'b0;
    case (state_q)
      ST_BOOT: begin
        next_pc = RESET_PC;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_i) begin
          next_pc = redirect_pc_i;
          // A misaligned target freezes the PC where it was.
          if (redirect_pc_i[1:0] != 2'b00) begin
            fault_entry = 1'b1;
            state_d     = ST_FAULT;
          end
        end else if (stall_i) begin
          next_pc = pc_q;
        end else begin
          next_pc = pc_inc;
        end
      end
      ST_FAULT: begin
        next_pc = pc_q;
      end
      default: begin
        next_pc = RESET_PC;
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (!fault_entry) pc_q <= next_pc;
    end
  end

  // Only the word-address bits reach the ROM, so high PCs alias back into it.
  assign rom_addr_o = next_pc[ADDR_WIDTH+1:2];
  assign valid_o    = (state_q == ST_RUN) && !redirect_i;
  assign instr_o    = valid_o ? rom_data_i : INSTR_NOP;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_inc;
  assign fault_o    = (state_q == ST_FAULT);

endmodule
